// File: rtl/ring_buffer_pkg.sv
// Shared types and constants for the ring buffer reader and its skid FIFO.
package ring_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam logic [SKID_CNT_W-1:0] SKID_FULL = SKID_CNT_W'(SKID_DEPTH);

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry registered skid FIFO; the head drives a valid/ready stream.
// The caller must not push while full unless the same cycle pops.
module reader_skid_fifo
  import ring_buffer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DW-1:0]         din,
  input  logic                  ready,
  output logic                  valid,
  output logic [DW-1:0]         dout,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DW-1:0]         mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr;
  logic [SKID_PTR_W-1:0] rd_ptr;
  logic                  pop;

  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign dout  = mem[rd_ptr];

  // When full, a push lands in the slot being popped this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + SKID_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + SKID_PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + SKID_CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - SKID_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ring_buffer_reader.sv
// Drains a programmed number of words from the ring buffer onto a valid/ready stream.
// Define RING_READER_LAST_EN to add the m_last_o end-of-burst marker.
module ring_buffer_reader
  import ring_buffer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LEN_BIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LEN_BIT-1:0] len_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               q_empty_i,
  output logic               q_dequeue_o,
  input  logic [WIDTH-1:0]   q_data_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [WIDTH-1:0]   m_data_o,
`ifdef RING_READER_LAST_EN
  output logic               m_last_o,
`endif
  output state_t             state_o
);

`ifdef RING_READER_LAST_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  state_t                  state;
  logic [LEN_BIT-1:0]      remaining;
  logic [SKID_CNT_W-1:0]   fifo_count;
  logic [FW-1:0]           fifo_din;
  logic [FW-1:0]           fifo_dout;
  logic                    pop;
  logic                    fifo_drained;

  // Stream handshake: a beat moves on every cycle where m_valid_o and
  // m_ready_i are both high; while m_ready_i is low the head word and
  // m_valid_o stay put until it is taken.
  assign pop = m_valid_o & m_ready_i;

  assign q_dequeue_o = (state == DRAIN) & ~rst & ~q_empty_i & (remaining != '0) &
                       ((fifo_count < SKID_FULL) | pop);

  // FIFO is empty after this edge: nothing held, or the sole word leaves now.
  assign fifo_drained = (fifo_count == '0) ||
                        ((fifo_count == SKID_CNT_W'(1)) && pop);

`ifdef RING_READER_LAST_EN
  assign fifo_din = {(remaining == LEN_BIT'(1)), q_data_i};
  assign m_last_o = m_valid_o & fifo_dout[WIDTH];
`else
  assign fifo_din = q_data_i;
`endif

  assign m_data_o = fifo_dout[WIDTH-1:0];
  assign state_o  = state;

  reader_skid_fifo #(
    .DW (FW)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (q_dequeue_o),
    .din   (fifo_din),
    .ready (m_ready_i),
    .valid (m_valid_o),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            remaining <= len_i;
            busy_o    <= 1'b1;
            if (len_i != '0) begin
              state  <= DRAIN;
              done_o <= 1'b0;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (q_dequeue_o) begin
            remaining <= remaining - LEN_BIT'(1);
          end
          if ((remaining == '0) || (q_dequeue_o && (remaining == LEN_BIT'(1)))) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifo_drained) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
